morra_sequencer: RTL and testbench
==================================

Name: morra_sequencer

Overview:
Match controller for the MorraCinese game core. It takes one match configuration, then collects one move per player through independent valid/ready handshakes. For each manche it presents both moves to the core in the same cycle, classifies the core's MANCHE/PARTITA answers and keeps per-match tallies. It holds the final match result until the host acknowledges it. It sits between the player/host interfaces and the core and is the only driver of the core's PRIMO/SECONDO/INIZIA inputs.

Parameters:
MIN_MANCHE, 4, minimum manche count of the core; max manches = MIN_MANCHE + CFG_SET
CNT_W, 5, width of tally counters (saturating)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
CFG_VALID  in  1  host offers a configuration
CFG_READY  out  1  sequencer accepts a configuration (IDLE only)
CFG_SET  in  4  manche offset; {PRIMO,SECONDO} value for the INIZIA cycle
ABORT  in  1  abandon current match and restart it with the latched CFG_SET
P1_VALID / P1_READY / P1_MOSSA  in/out/in  1/1/2  player 1 move handshake
P2_VALID / P2_READY / P2_MOSSA  in/out/in  1/1/2  player 2 move handshake
G_PRIMO  out  2  to core PRIMO
G_SECONDO  out  2  to core SECONDO
G_INIZIA  out  1  to core INIZIA
G_MANCHE  in  2  from core MANCHE
G_PARTITA  in  2  from core PARTITA
RIS_VALID  out  1  match result available
RIS_ACK  in  1  host consumes result
RIS_PARTITA  out  2  01 p1, 10 p2, 11 draw, 00 only with RIS_ERR
RIS_ERR  out  1  core exceeded max manches without declaring PARTITA
CONT1, CONT2, CONTP, CONT_INV  out  CNT_W each  p1 wins, p2 wins, drawn manches, invalid manches

Behaviour:
- The interface uses one clock, clk. Reset is synchronous and active-low (rst_n); it is checked before anything else on every edge.
- rst_n=0 at a posedge gives:
  - state IDLE;
  - all counters 0; RIS_* 0; latched config 0; move-held flags 0;
  - G_PRIMO=G_SECONDO=00, G_INIZIA=0.
- G_*, *_READY and RIS_* are decoded from registered state and registers only; none is combinational from inputs.
- In any state where moves are not being driven, G_PRIMO/G_SECONDO=00. The core ignores 00 moves.
- States:
  - IDLE: CFG_READY=1. If CFG_VALID=1, latch CFG_SET and go to CONFIG.
  - CONFIG (1 cycle):
    - drive G_INIZIA=1, G_PRIMO=cfg[3:2], G_SECONDO=cfg[1:0];
    - clear counters, RIS_*, and held flags;
    - go to COLLECT.
  - COLLECT:
    - Pn_READY=1 while the Pn move is not yet held. A handshake (VALID&READY) latches Pn_MOSSA and sets held_n.
    - Both handshakes may complete in the same cycle.
    - 00 moves are accepted and forwarded unchanged; the core judges them invalid.
    - When both held flags are set at the posedge, go to PLAY.
  - PLAY (1 cycle): drive the latched moves, G_INIZIA=0; clear held flags; go to EVAL.
  - EVAL (1 cycle): drive 00/00.
    - Sample G_MANCHE: 01 increments CONT1, 10 increments CONT2, 11 increments CONTP, 00 increments CONT_INV. All counters saturate at 2^CNT_W-1.
    - If G_PARTITA!=00: latch RIS_PARTITA=G_PARTITA and go to FLUSH.
    - Else if CONT1+CONT2+CONTP (post-increment) > MIN_MANCHE+cfg: set RIS_ERR=1, RIS_PARTITA=00, go to FLUSH.
    - Otherwise go to COLLECT.
  - FLUSH (1 cycle): drive 00/00, INIZIA=0. This lets the core pass through its FINE state. Then go to DONE.
  - DONE: RIS_VALID=1; RIS_PARTITA, RIS_ERR and counters are held stable. If RIS_ACK=1, go to IDLE. RIS_VALID stays low from IDLE until the next DONE.
- Latency:
  - CFG accept to first P*_READY: 2 cycles.
  - Last move handshake to counter update: 2 cycles (PLAY, EVAL).
  - Final manche's moves to RIS_VALID: 3 cycles.
- ABORT=1 in any state other than IDLE: next state is CONFIG with the previously latched cfg. The current match is discarded:
  - counters cleared, held moves dropped, RIS_VALID drops;
  - ABORT takes priority over RIS_ACK and over handshakes in the same cycle;
  - ABORT in IDLE is ignored.
- CFG_VALID outside IDLE is ignored (CFG_READY=0).
- P*_READY=0 outside COLLECT.
- A player that offers a move early keeps VALID high until COLLECT.
- Max manches = MIN_MANCHE+CFG_SET, range 4..19, 5-bit arithmetic with no overflow.

Test Plan:
- Reset and config:
  - Stimulus: hold rst_n=0 two cycles, then CFG_SET=0101 with CFG_VALID.
  - Required: one cycle with G_INIZIA=1, G_PRIMO=01, G_SECONDO=01; then P1_READY=P2_READY=1.
- P1 sweep:
  - Stimulus: CFG_SET=0000 (max 4), then moves (01,11), (10,01), (11,10), (01,11).
  - Required: RIS_VALID=1 with RIS_PARTITA=01, CONT1=4, CONT2=CONTP=CONT_INV=0, 3 cycles after the 4th PLAY.
- Invalid and repeat moves:
  - Stimulus: CFG_SET=0000; (00,10), then (01,11), then (01,10). P1 repeats its winning 01.
  - Required: CONT_INV=2, CONT1=1, no RIS_VALID.
- Skewed handshakes:
  - Stimulus: P1 valid at cycle t, P2 at t+5.
  - Required: P1_READY=0 from t+1; PLAY at t+6; moves driven for exactly one cycle.
- ABORT mid-match:
  - Stimulus: CFG_SET=0011, play 2 manches, then ABORT.
  - Required: one G_INIZIA cycle with 00/11; all counters 0; a new match is playable.
- Result hold and ack:
  - Stimulus: reach DONE; keep RIS_ACK=0 for 10 cycles, then pulse it.
  - Required: RIS_* stable throughout; IDLE next cycle with CFG_READY=1.

Source files
------------

// File: rtl/morra_sequencer.sv
// Match controller for the MorraCinese core: takes a configuration, collects one
// move per player, feeds each manche to the core and tallies the answers.
module morra_sequencer #(
   parameter int MIN_MANCHE = 4,
   parameter int CNT_W      = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             CFG_VALID,
   output logic             CFG_READY,
   input  logic [3:0]       CFG_SET,
   input  logic             ABORT,
   input  logic             P1_VALID,
   output logic             P1_READY,
   input  logic [1:0]       P1_MOSSA,
   input  logic             P2_VALID,
   output logic             P2_READY,
   input  logic [1:0]       P2_MOSSA,
   output logic [1:0]       G_PRIMO,
   output logic [1:0]       G_SECONDO,
   output logic             G_INIZIA,
   input  logic [1:0]       G_MANCHE,
   input  logic [1:0]       G_PARTITA,
   output logic             RIS_VALID,
   input  logic             RIS_ACK,
   output logic [1:0]       RIS_PARTITA,
   output logic             RIS_ERR,
   output logic [CNT_W-1:0] CONT1,
   output logic [CNT_W-1:0] CONT2,
   output logic [CNT_W-1:0] CONTP,
   output logic [CNT_W-1:0] CONT_INV
);

   typedef enum logic [2:0] {
      IDLE,
      CONFIG,
      COLLECT,
      PLAY,
      EVAL,
      FLUSH,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int               SUM_W   = CNT_W + 2;

   state_t           state_q, state_d;
   logic [3:0]       cfg_q, cfg_d;
   logic [1:0]       mossa1_q, mossa1_d;
   logic [1:0]       mossa2_q, mossa2_d;
   logic             held1_q, held1_d;
   logic             held2_q, held2_d;
   logic [CNT_W-1:0] cont1_q, cont1_d;
   logic [CNT_W-1:0] cont2_q, cont2_d;
   logic [CNT_W-1:0] contp_q, contp_d;
   logic [CNT_W-1:0] cont_inv_q, cont_inv_d;
   logic [1:0]       ris_partita_q, ris_partita_d;
   logic             ris_err_q, ris_err_d;
   logic [SUM_W-1:0] played_sum;
   logic [SUM_W-1:0] max_manche;
   logic             fire1, fire2;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign max_manche = SUM_W'(MIN_MANCHE) + SUM_W'(cfg_q);
   assign fire1      = P1_VALID & P1_READY;
   assign fire2      = P2_VALID & P2_READY;

   always_comb begin
      state_d       = state_q;
      cfg_d         = cfg_q;
      mossa1_d      = mossa1_q;
      mossa2_d      = mossa2_q;
      held1_d       = held1_q;
      held2_d       = held2_q;
      cont1_d       = cont1_q;
      cont2_d       = cont2_q;
      contp_d       = contp_q;
      cont_inv_d    = cont_inv_q;
      ris_partita_d = ris_partita_q;
      ris_err_d     = ris_err_q;
      played_sum    = '0;
      case (state_q)
         IDLE: begin
            if (CFG_VALID) begin
               cfg_d   = CFG_SET;
               state_d = CONFIG;
            end
         end
         CONFIG: begin
            held1_d       = 1'b0;
            held2_d       = 1'b0;
            cont1_d       = '0;
            cont2_d       = '0;
            contp_d       = '0;
            cont_inv_d    = '0;
            ris_partita_d = 2'b00;
            ris_err_d     = 1'b0;
            state_d       = COLLECT;
         end
         COLLECT: begin
            if (fire1) begin
               mossa1_d = P1_MOSSA;
               held1_d  = 1'b1;
            end
            if (fire2) begin
               mossa2_d = P2_MOSSA;
               held2_d  = 1'b1;
            end
            if (held1_d && held2_d) state_d = PLAY;
         end
         PLAY: begin
            held1_d = 1'b0;
            held2_d = 1'b0;
            state_d = EVAL;
         end
         EVAL: begin
            case (G_MANCHE)
               2'b01:   cont1_d    = sat_inc(cont1_q);
               2'b10:   cont2_d    = sat_inc(cont2_q);
               2'b11:   contp_d    = sat_inc(contp_q);
               default: cont_inv_d = sat_inc(cont_inv_q);
            endcase
            // Overrun is judged on the tallies including this manche.
            played_sum = SUM_W'(cont1_d) + SUM_W'(cont2_d) + SUM_W'(contp_d);
            if (G_PARTITA != 2'b00) begin
               ris_partita_d = G_PARTITA;
               state_d       = FLUSH;
            end else if (played_sum > max_manche) begin
               ris_err_d     = 1'b1;
               ris_partita_d = 2'b00;
               state_d       = FLUSH;
            end else begin
               state_d = COLLECT;
            end
         end
         FLUSH: state_d = DONE;
         DONE: begin
            if (RIS_ACK) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort overrides everything decided above and replays the latched config.
      if (ABORT && (state_q != IDLE)) begin
         state_d       = CONFIG;
         held1_d       = 1'b0;
         held2_d       = 1'b0;
         cont1_d       = '0;
         cont2_d       = '0;
         contp_d       = '0;
         cont_inv_d    = '0;
         ris_partita_d = 2'b00;
         ris_err_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cfg_q         <= 4'b0000;
         mossa1_q      <= 2'b00;
         mossa2_q      <= 2'b00;
         held1_q       <= 1'b0;
         held2_q       <= 1'b0;
         cont1_q       <= '0;
         cont2_q       <= '0;
         contp_q       <= '0;
         cont_inv_q    <= '0;
         ris_partita_q <= 2'b00;
         ris_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cfg_q         <= cfg_d;
         mossa1_q      <= mossa1_d;
         mossa2_q      <= mossa2_d;
         held1_q       <= held1_d;
         held2_q       <= held2_d;
         cont1_q       <= cont1_d;
         cont2_q       <= cont2_d;
         contp_q       <= contp_d;
         cont_inv_q    <= cont_inv_d;
         ris_partita_q <= ris_partita_d;
         ris_err_q     <= ris_err_d;
      end
   end

   assign CFG_READY   = (state_q == IDLE);
   assign P1_READY    = (state_q == COLLECT) && !held1_q;
   assign P2_READY    = (state_q == COLLECT) && !held2_q;
   assign G_INIZIA    = (state_q == CONFIG);
   assign G_PRIMO     = (state_q == CONFIG) ? cfg_q[3:2] :
                        (state_q == PLAY)   ? mossa1_q   : 2'b00;
   assign G_SECONDO   = (state_q == CONFIG) ? cfg_q[1:0] :
                        (state_q == PLAY)   ? mossa2_q   : 2'b00;
   assign RIS_VALID   = (state_q == DONE);
   assign RIS_PARTITA = ris_partita_q;
   assign RIS_ERR     = ris_err_q;
   assign CONT1       = cont1_q;
   assign CONT2       = cont2_q;
   assign CONTP       = contp_q;
   assign CONT_INV    = cont_inv_q;

endmodule

// File: tb/tb_morra_sequencer.sv
// Bench for morra_sequencer: a behavioural MorraCinese core answers each manche and a
// match-level model predicts tallies and results from the list of manche outcomes.
module tb_morra_sequencer;

   localparam int MIN_MANCHE = 4;
   localparam int CNT_W      = 5;
   localparam int CNT_SAT    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             CFG_VALID, CFG_READY;
   logic [3:0]       CFG_SET;
   logic             ABORT;
   logic             P1_VALID, P1_READY, P2_VALID, P2_READY;
   logic [1:0]       P1_MOSSA, P2_MOSSA;
   logic [1:0]       G_PRIMO, G_SECONDO;
   logic             G_INIZIA;
   logic [1:0]       G_MANCHE, G_PARTITA;
   logic             RIS_VALID, RIS_ACK, RIS_ERR;
   logic [1:0]       RIS_PARTITA;
   logic [CNT_W-1:0] CONT1, CONT2, CONTP, CONT_INV;

   int errorCount = 0;
   int checkCount = 0;

   morra_sequencer #(.MIN_MANCHE(MIN_MANCHE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_SET(CFG_SET), .ABORT(ABORT),
      .P1_VALID(P1_VALID), .P1_READY(P1_READY), .P1_MOSSA(P1_MOSSA),
      .P2_VALID(P2_VALID), .P2_READY(P2_READY), .P2_MOSSA(P2_MOSSA),
      .G_PRIMO(G_PRIMO), .G_SECONDO(G_SECONDO), .G_INIZIA(G_INIZIA),
      .G_MANCHE(G_MANCHE), .G_PARTITA(G_PARTITA),
      .RIS_VALID(RIS_VALID), .RIS_ACK(RIS_ACK), .RIS_PARTITA(RIS_PARTITA), .RIS_ERR(RIS_ERR),
      .CONT1(CONT1), .CONT2(CONT2), .CONTP(CONTP), .CONT_INV(CONT_INV)
   );

   always #5 clk = ~clk;

   // Game rules: 01 sasso, 10 carta, 11 forbice; a manche winner may not reuse its winning move.
   function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] lastW, input logic [1:0] lastM);
      if (a == 2'b00 || b == 2'b00) return 2'b00;
      if (lastW == 2'b01 && a == lastM) return 2'b00;
      if (lastW == 2'b10 && b == lastM) return 2'b00;
      if (a == b) return 2'b11;
      if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10))
         return 2'b01;
      return 2'b10;
   endfunction

   function automatic logic [1:0] winnerCode(input int w1, input int w2);
      if (w1 > w2) return 2'b01;
      if (w2 > w1) return 2'b10;
      return 2'b11;
   endfunction

   // Behavioural core: declares the match once its valid manches reach the maximum,
   // unless muted, in which case it never declares and the sequencer must flag overrun.
   logic       coreMute;
   int         coreMax, coreValid, coreW1, coreW2;
   logic [1:0] coreLastW, coreLastM, coreNow;

   always_comb coreNow = judge(G_PRIMO, G_SECONDO, coreLastW, coreLastM);

   always @(posedge clk) begin
      if (!rst_n || G_INIZIA) begin
         coreMax   <= MIN_MANCHE + int'({G_PRIMO, G_SECONDO});
         coreValid <= 0;
         coreW1    <= 0;
         coreW2    <= 0;
         coreLastW <= 2'b00;
         coreLastM <= 2'b00;
         G_MANCHE  <= 2'b00;
         G_PARTITA <= 2'b00;
      end else if (G_PRIMO != 2'b00 || G_SECONDO != 2'b00) begin
         G_MANCHE <= coreNow;
         if (coreNow != 2'b00) begin
            coreValid <= coreValid + 1;
            coreW1    <= coreW1 + int'(coreNow == 2'b01);
            coreW2    <= coreW2 + int'(coreNow == 2'b10);
            coreLastW <= (coreNow == 2'b11) ? 2'b00 : coreNow;
            coreLastM <= (coreNow == 2'b10) ? G_SECONDO : G_PRIMO;
            if (!coreMute && coreValid + 1 == coreMax)
               G_PARTITA <= winnerCode(coreW1 + int'(coreNow == 2'b01), coreW2 + int'(coreNow == 2'b10));
            else
               G_PARTITA <= 2'b00;
         end else begin
            G_PARTITA <= 2'b00;
         end
      end else begin
         G_MANCHE  <= 2'b00;
         G_PARTITA <= 2'b00;
      end
   end

   // Match-level reference model: list of manche outcomes plus the move history.
   logic [1:0] outcomes[$];
   int         modelMax;
   logic [1:0] modelLastW, modelLastM;
   int         expC1, expC2, expCp, expCi;
   logic [1:0] expPartita;
   logic       expErr;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic modelReset(input logic [3:0] cfg);
      outcomes.delete();
      modelMax   = MIN_MANCHE + int'(cfg);
      modelLastW = 2'b00;
      modelLastM = 2'b00;
   endtask

   // Adds one manche and returns whether the match is over.
   task automatic modelManche(input logic [1:0] m1, input logic [1:0] m2, output bit ended);
      logic [1:0] r;
      int w1, w2, d, inv;
      r = judge(m1, m2, modelLastW, modelLastM);
      if (r != 2'b00) begin
         modelLastW = (r == 2'b11) ? 2'b00 : r;
         modelLastM = (r == 2'b10) ? m2 : m1;
      end
      outcomes.push_back(r);
      w1 = 0; w2 = 0; d = 0; inv = 0;
      foreach (outcomes[i]) begin
         if (outcomes[i] == 2'b01) w1++;
         else if (outcomes[i] == 2'b10) w2++;
         else if (outcomes[i] == 2'b11) d++;
         else inv++;
      end
      expC1 = (w1 > CNT_SAT) ? CNT_SAT : w1;
      expC2 = (w2 > CNT_SAT) ? CNT_SAT : w2;
      expCp = (d > CNT_SAT) ? CNT_SAT : d;
      expCi = (inv > CNT_SAT) ? CNT_SAT : inv;
      expPartita = 2'b00;
      expErr     = 1'b0;
      if (!coreMute && r != 2'b00 && (w1 + w2 + d) == modelMax) expPartita = winnerCode(w1, w2);
      else if (expC1 + expC2 + expCp > modelMax) expErr = 1'b1;
      ended = (expPartita != 2'b00) || expErr;
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_cont1"}, 32'(CONT1), expC1);
      checkOutput({tag, "_cont2"}, 32'(CONT2), expC2);
      checkOutput({tag, "_contp"}, 32'(CONTP), expCp);
      checkOutput({tag, "_continv"}, 32'(CONT_INV), expCi);
   endtask

   // Called at the negedge of the CONFIG cycle.
   task automatic checkConfigCycle(input logic [3:0] cfg);
      checkOutput("cfg_inizia", 32'(G_INIZIA), 1);
      checkOutput("cfg_moves", 32'({G_PRIMO, G_SECONDO}), 32'(cfg));
      checkOutput("cfg_p1_ready", 32'(P1_READY), 0);
      checkOutput("cfg_ris_valid", 32'(RIS_VALID), 0);
      modelReset(cfg);
      expC1 = 0; expC2 = 0; expCp = 0; expCi = 0;
      @(negedge clk);
      checkOutput("collect_p1_ready", 32'(P1_READY), 1);
      checkOutput("collect_p2_ready", 32'(P2_READY), 1);
      checkOutput("collect_inizia", 32'(G_INIZIA), 0);
      checkCounters("cleared");
   endtask

   task automatic applyStimulus(input logic [3:0] cfg);
      int cyc = 0;
      while (!CFG_READY && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("cfg_ready_wait", 32'(CFG_READY), 1);
      CFG_SET   = cfg;
      CFG_VALID = 1'b1;
      @(negedge clk);
      CFG_VALID = 1'b0;
      CFG_SET   = 4'($urandom);
      checkConfigCycle(cfg);
   endtask

   // Starts at a COLLECT negedge and returns at the PLAY negedge.
   task automatic playManche(input logic [1:0] m1, input logic [1:0] m2, input int d1, input int d2);
      bit h1 = 0, h2 = 0, f1, f2, stall1 = 0, stall2 = 0;
      int cyc = 0;
      while (!(h1 && h2) && cyc < 60) begin
         P1_VALID = !h1 && cyc >= d1;
         P2_VALID = !h2 && cyc >= d2;
         P1_MOSSA = m1;
         P2_MOSSA = m2;
         f1 = P1_VALID && P1_READY;
         f2 = P2_VALID && P2_READY;
         @(negedge clk);
         cyc++;
         if (f1) h1 = 1;
         if (f2) h2 = 1;
         if (h1 && !h2 && !stall1) begin
            checkOutput("p1_ready_drop", 32'(P1_READY), 0);
            stall1 = 1;
         end
         if (h2 && !h1 && !stall2) begin
            checkOutput("p2_ready_drop", 32'(P2_READY), 0);
            stall2 = 1;
         end
      end
      P1_VALID = 1'b0;
      P2_VALID = 1'b0;
      checkOutput("play_latency", cyc, ((d1 > d2) ? d1 : d2) + 1);
      checkOutput("play_moves", 32'({G_PRIMO, G_SECONDO}), 32'({m1, m2}));
      checkOutput("play_inizia", 32'(G_INIZIA), 0);
   endtask

   task automatic playAndCheck(input logic [1:0] m1, input logic [1:0] m2,
                               input int d1, input int d2, output bit ended);
      playManche(m1, m2, d1, d2);
      @(negedge clk);
      checkOutput("eval_moves", 32'({G_PRIMO, G_SECONDO}), 0);
      modelManche(m1, m2, ended);
      @(negedge clk);
      checkCounters("tally");
      checkOutput("after_eval_ris_valid", 32'(RIS_VALID), 0);
      if (ended) begin
         checkOutput("flush_moves", 32'({G_PRIMO, G_SECONDO, G_INIZIA}), 0);
         @(negedge clk);
         checkOutput("done_ris_valid", 32'(RIS_VALID), 1);
         checkOutput("done_partita", 32'(RIS_PARTITA), 32'(expPartita));
         checkOutput("done_err", 32'(RIS_ERR), 32'(expErr));
         checkCounters("done");
      end else begin
         checkOutput("next_p1_ready", 32'(P1_READY), 1);
      end
   endtask

   function automatic logic [1:0] randomMove();
      return ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
   endfunction

   task automatic runRandomMatch();
      bit ended = 0;
      int n = 0;
      while (!ended && n < 80) begin
         playAndCheck(randomMove(), randomMove(), $urandom_range(0, 3), $urandom_range(0, 3), ended);
         n++;
      end
      checkOutput("match_end", 32'(ended), 1);
   endtask

   task automatic ackResult(input int hold);
      repeat (hold) @(negedge clk);
      checkOutput("hold_ris_valid", 32'(RIS_VALID), 1);
      checkOutput("hold_partita", 32'(RIS_PARTITA), 32'(expPartita));
      checkOutput("hold_err", 32'(RIS_ERR), 32'(expErr));
      checkCounters("hold");
      RIS_ACK = 1'b1;
      @(negedge clk);
      RIS_ACK = 1'b0;
      checkOutput("ack_cfg_ready", 32'(CFG_READY), 1);
      checkOutput("ack_ris_valid", 32'(RIS_VALID), 0);
   endtask

   initial begin
      logic [1:0] sweep1[4] = '{2'b01, 2'b10, 2'b11, 2'b01};
      logic [1:0] sweep2[4] = '{2'b11, 2'b01, 2'b10, 2'b11};
      logic [1:0] inv1[3]   = '{2'b00, 2'b01, 2'b01};
      logic [1:0] inv2[3]   = '{2'b10, 2'b11, 2'b10};
      logic [3:0] cfg;
      bit ended;

      rst_n = 1'b0; CFG_VALID = 1'b0; CFG_SET = 4'b0000; ABORT = 1'b0;
      P1_VALID = 1'b0; P2_VALID = 1'b0; P1_MOSSA = 2'b00; P2_MOSSA = 2'b00;
      RIS_ACK = 1'b0; coreMute = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_cfg_ready", 32'(CFG_READY), 1);
      checkOutput("rst_outputs", 32'({G_PRIMO, G_SECONDO, G_INIZIA, P1_READY, P2_READY}), 0);
      checkOutput("rst_ris", 32'({RIS_VALID, RIS_PARTITA, RIS_ERR}), 0);
      expC1 = 0; expC2 = 0; expCp = 0; expCi = 0;
      checkCounters("rst");
      rst_n = 1'b1;

      ABORT = 1'b1;
      @(negedge clk);
      ABORT = 1'b0;
      checkOutput("idle_abort_ready", 32'(CFG_READY), 1);
      checkOutput("idle_abort_inizia", 32'(G_INIZIA), 0);

      $display("[TB] config 0101 and random match");
      applyStimulus(4'b0101);
      runRandomMatch();
      ackResult(1);

      $display("[TB] p1 sweep");
      applyStimulus(4'b0000);
      for (int i = 0; i < 4; i++)
         playAndCheck(sweep1[i], sweep2[i], $urandom_range(0, 2), $urandom_range(0, 2), ended);
      checkOutput("sweep_ended", 32'(ended), 1);
      checkOutput("sweep_partita", 32'(RIS_PARTITA), 1);
      checkOutput("sweep_cont1", 32'(CONT1), 4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("hold_stable", 32'({RIS_VALID, RIS_PARTITA, RIS_ERR, CONT1}), 32'({1'b1, 2'b01, 1'b0, 5'd4}));
      end
      ackResult(0);

      $display("[TB] invalid and repeated moves, then abort");
      applyStimulus(4'b0000);
      for (int i = 0; i < 3; i++) playAndCheck(inv1[i], inv2[i], 0, 1, ended);
      checkOutput("inv_cont_inv", 32'(CONT_INV), 2);
      checkOutput("inv_cont1", 32'(CONT1), 1);
      checkOutput("inv_no_result", 32'(RIS_VALID), 0);
      CFG_SET = 4'b1111; CFG_VALID = 1'b1;
      checkOutput("busy_cfg_ready", 32'(CFG_READY), 0);
      @(negedge clk);
      CFG_VALID = 1'b0;
      ABORT = 1'b1; P1_VALID = 1'b1; P1_MOSSA = 2'b10;
      @(negedge clk);
      ABORT = 1'b0; P1_VALID = 1'b0;
      checkConfigCycle(4'b0000);
      runRandomMatch();
      ackResult($urandom_range(0, 3));

      $display("[TB] skewed handshakes and abort mid-match");
      applyStimulus(4'b0011);
      playAndCheck(2'b01, 2'b10, 0, 5, ended);
      playAndCheck(randomMove(), randomMove(), 3, 0, ended);
      ABORT = 1'b1;
      @(negedge clk);
      ABORT = 1'b0;
      checkConfigCycle(4'b0011);
      runRandomMatch();
      ackResult(2);

      $display("[TB] core never declares: overrun, abort over ack, saturation");
      coreMute = 1'b1;
      cfg = 4'($urandom_range(0, 3));
      applyStimulus(cfg);
      runRandomMatch();
      checkOutput("overrun_err", 32'(RIS_ERR), 1);
      ABORT = 1'b1; RIS_ACK = 1'b1;
      @(negedge clk);
      ABORT = 1'b0; RIS_ACK = 1'b0;
      checkConfigCycle(cfg);
      for (int i = 0; i < CNT_SAT + 3; i++) playAndCheck(2'b00, 2'b00, 0, 0, ended);
      checkOutput("sat_cont_inv", 32'(CONT_INV), CNT_SAT);
      coreMute = 1'b0;
      runRandomMatch();
      ackResult(1);

      $display("[TB] random configurations");
      for (int k = 0; k < 3; k++) begin
         coreMute = 1'($urandom_range(0, 1));
         applyStimulus(4'($urandom));
         runRandomMatch();
         ackResult($urandom_range(0, 4));
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: observed=1 expected=0");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
